// File: rtl/led_pwr_sequencer_if.sv
// Front-panel LED controller signal bundle: platform status in, active-low LED drives and phase out.
// master = status source / consumer side, slave = led_pwr_sequencer.
interface led_pwr_sequencer_if;
  logic       PsEn;
  logic [1:0] SysHealth;
  logic [1:0] PsuOk;
  logic [1:0] PsuFail;
  logic       FanFail;
  logic [1:0] LanLink1000;
  logic [1:0] LanLink100;
  logic [1:0] LanAct;

  logic       SysLedG_ox;
  logic       SysLedR_ox;
  logic       FanFail_ox;
  logic       FanOK_ox;
  logic [1:0] PowerNormal_ox;
  logic [1:0] PowerFail_ox;
  logic [1:0] RJ45Speed1R_ox;
  logic [1:0] RJ45Speed2R_ox;
  logic [1:0] RJ45RActivity_ox;
  logic [1:0] LedPhase;

  modport master (
    output PsEn, SysHealth, PsuOk, PsuFail, FanFail, LanLink1000, LanLink100, LanAct,
    input  SysLedG_ox, SysLedR_ox, FanFail_ox, FanOK_ox, PowerNormal_ox, PowerFail_ox,
           RJ45Speed1R_ox, RJ45Speed2R_ox, RJ45RActivity_ox, LedPhase
  );

  modport slave (
    input  PsEn, SysHealth, PsuOk, PsuFail, FanFail, LanLink1000, LanLink100, LanAct,
    output SysLedG_ox, SysLedR_ox, FanFail_ox, FanOK_ox, PowerNormal_ox, PowerFail_ox,
           RJ45Speed1R_ox, RJ45Speed2R_ox, RJ45RActivity_ox, LedPhase
  );
endinterface

// File: rtl/led_pwr_sequencer.sv
// Power-up LED sequencer: OFF -> SETTLE -> (LAMP) -> RUN, with ms prescaler, SYS blink and LAN activity stretch.
// Define LED_LAMP_TEST_EN to include the lamp-test phase; otherwise SETTLE goes straight to RUN.
module led_pwr_sequencer #(
  parameter int unsigned CLK_PER_MS = 33000,
  parameter int unsigned SETTLE_MS  = 200,
  parameter int unsigned LAMP_MS    = 1000,
  parameter int unsigned BLINK_MS   = 500,
  parameter int unsigned ACT_MS     = 50
) (
  input  logic Mclk,
  input  logic Reset,
  led_pwr_sequencer_if.slave panel
);

  localparam int unsigned MAX_SL = (SETTLE_MS > LAMP_MS) ? SETTLE_MS : LAMP_MS;
  localparam int unsigned MAX_MS = (MAX_SL > BLINK_MS) ? MAX_SL : BLINK_MS;
  localparam int unsigned MS_W   = $clog2(MAX_MS + 1);
  localparam int unsigned PRE_W  = $clog2(CLK_PER_MS);
  localparam int unsigned ACT_W  = $clog2(ACT_MS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]  SETTLE_LAST = MS_W'(SETTLE_MS - 1);
  localparam logic [MS_W-1:0]  BLINK_LAST  = MS_W'(BLINK_MS - 1);
  localparam logic [ACT_W-1:0] ACT_LAST    = ACT_W'(ACT_MS - 1);
`ifdef LED_LAMP_TEST_EN
  localparam logic [MS_W-1:0]  LAMP_LAST   = MS_W'(LAMP_MS - 1);
`endif

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    SETTLE = 2'b01,
    LAMP   = 2'b10,
    RUN    = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_ON,
    ACT_GAP
  } act_t;

  typedef struct packed {
    logic       sys_g;
    logic       sys_r;
    logic       fan_fail;
    logic       fan_ok;
    logic [1:0] pwr_normal;
    logic [1:0] pwr_fail;
    logic [1:0] speed1;
    logic [1:0] speed2;
    logic [1:0] activity;
  } leds_t;

  phase_t           phase;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [MS_W-1:0]  ms_cnt;
  logic             blink;
  logic [1:0]       stretch_on;
  leds_t            leds;
  leds_t            run_leds;

  // Free-running millisecond prescaler, independent of the sequencer phase.
  always_ff @(posedge Mclk or posedge Reset) begin
    if (Reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRE_LAST);

  // Run-mode LED image from live status; outputs are active-low.
  always_comb begin
    run_leds            = '1;
    run_leds.sys_g      = ~((panel.SysHealth == 2'b00) | ((panel.SysHealth == 2'b11) & blink));
    run_leds.sys_r      = ~((panel.SysHealth == 2'b10) | ((panel.SysHealth == 2'b01) & blink));
    run_leds.pwr_normal = ~(panel.PsuOk & ~panel.PsuFail);
    run_leds.pwr_fail   = ~panel.PsuFail;
    run_leds.fan_fail   = ~panel.FanFail;
    run_leds.fan_ok     = panel.FanFail;
    run_leds.speed1     = ~panel.LanLink1000;
    run_leds.speed2     = ~(panel.LanLink100 & ~panel.LanLink1000);
    run_leds.activity   = ~(stretch_on & (panel.LanLink1000 | panel.LanLink100));
  end

  // blink is only ever non-zero in RUN, so run_leds at RUN entry already sees it cleared.
  always_ff @(posedge Mclk or posedge Reset) begin
    if (Reset) begin
      phase  <= OFF;
      ms_cnt <= '0;
      blink  <= 1'b0;
      leds   <= '1;
    end else if (!panel.PsEn) begin
      phase  <= OFF;
      ms_cnt <= '0;
      blink  <= 1'b0;
      leds   <= '1;
    end else begin
      case (phase)
        OFF: begin
          phase  <= SETTLE;
          ms_cnt <= '0;
          leds   <= '1;
        end
        SETTLE: begin
          leds <= '1;
          if (tick) begin
            if (ms_cnt == SETTLE_LAST) begin
              ms_cnt <= '0;
`ifdef LED_LAMP_TEST_EN
              phase  <= LAMP;
              leds   <= '0;
`else
              phase  <= RUN;
              leds   <= run_leds;
`endif
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
`ifdef LED_LAMP_TEST_EN
        LAMP: begin
          leds <= '0;
          if (tick) begin
            if (ms_cnt == LAMP_LAST) begin
              ms_cnt <= '0;
              phase  <= RUN;
              leds   <= run_leds;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
`endif
        RUN: begin
          leds <= run_leds;
          if (tick) begin
            if (ms_cnt == BLINK_LAST) begin
              ms_cnt <= '0;
              blink  <= ~blink;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        default: begin
          phase  <= OFF;
          ms_cnt <= '0;
          blink  <= 1'b0;
          leds   <= '1;
        end
      endcase
    end
  end

  // Per-port activity stretcher: ACT_MS on, ACT_MS forced off, retriggered only from IDLE.
  for (genvar i = 0; i < 2; i++) begin : g_act
    act_t             st;
    logic [ACT_W-1:0] cnt;

    always_ff @(posedge Mclk or posedge Reset) begin
      if (Reset) begin
        st  <= ACT_IDLE;
        cnt <= '0;
      end else if (phase != RUN) begin
        st  <= ACT_IDLE;
        cnt <= '0;
      end else begin
        case (st)
          ACT_IDLE: begin
            if (panel.LanAct[i]) begin
              st  <= ACT_ON;
              cnt <= '0;
            end
          end
          ACT_ON: begin
            if (tick) begin
              if (cnt == ACT_LAST) begin
                st  <= ACT_GAP;
                cnt <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ACT_GAP: begin
            if (tick) begin
              if (cnt == ACT_LAST) begin
                st  <= ACT_IDLE;
                cnt <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: begin
            st  <= ACT_IDLE;
            cnt <= '0;
          end
        endcase
      end
    end

    assign stretch_on[i] = (st == ACT_ON);
  end

  assign panel.SysLedG_ox       = leds.sys_g;
  assign panel.SysLedR_ox       = leds.sys_r;
  assign panel.FanFail_ox       = leds.fan_fail;
  assign panel.FanOK_ox         = leds.fan_ok;
  assign panel.PowerNormal_ox   = leds.pwr_normal;
  assign panel.PowerFail_ox     = leds.pwr_fail;
  assign panel.RJ45Speed1R_ox   = leds.speed1;
  assign panel.RJ45Speed2R_ox   = leds.speed2;
  assign panel.RJ45RActivity_ox = leds.activity;
  assign panel.LedPhase         = phase;

endmodule

// File: tb/tb_led_pwr_sequencer.sv
// Randomized bench for led_pwr_sequencer against a tick-counting reference model.
// Follows LED_LAMP_TEST_EN the same way the design does.
module tb_led_pwr_sequencer;

  localparam int C = 4;
  localparam int S = 3;
  localparam int L = 2;
  localparam int B = 2;
  localparam int A = 2;
`ifdef LED_LAMP_TEST_EN
  localparam int RUN_AT = S + L;
`else
  localparam int RUN_AT = S;
`endif

  logic Mclk  = 1'b0;
  logic Reset = 1'b1;

  logic       ps_en = 1'b0;
  logic [1:0] health = 2'b00, psu_ok = 2'b00, psu_fail = 2'b00;
  logic       fan_fail = 1'b0;
  logic [1:0] l1000 = 2'b00, l100 = 2'b00, lan_act = 2'b00;

  led_pwr_sequencer_if panel();

  assign panel.PsEn        = ps_en;
  assign panel.SysHealth   = health;
  assign panel.PsuOk       = psu_ok;
  assign panel.PsuFail     = psu_fail;
  assign panel.FanFail     = fan_fail;
  assign panel.LanLink1000 = l1000;
  assign panel.LanLink100  = l100;
  assign panel.LanAct      = lan_act;

  led_pwr_sequencer #(
    .CLK_PER_MS(C),
    .SETTLE_MS (S),
    .LAMP_MS   (L),
    .BLINK_MS  (B),
    .ACT_MS    (A)
  ) dut (
    .Mclk (Mclk),
    .Reset(Reset),
    .panel(panel)
  );

  always #5 Mclk = ~Mclk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase from ticks elapsed since power-on, blink from ticks elapsed in RUN.
  int   mp;
  bit   on;
  int   ticks;
  bit   busy [2];
  int   aticks [2];

  logic [1:0] exp_phase;
  logic [1:0] exp_sys;
  logic [3:0] exp_pwr;
  logic [1:0] exp_fan;
  logic [5:0] exp_lan;

  function automatic int phase_of(input bit o, input int t);
    if (!o) return 0;
    if (t < S) return 1;
`ifdef LED_LAMP_TEST_EN
    if (t < S + L) return 2;
`endif
    return 3;
  endfunction

  task automatic model_reset();
    mp = 0; on = 0; ticks = 0;
    for (int i = 0; i < 2; i++) begin busy[i] = 0; aticks[i] = 0; end
    exp_phase = 2'b00; exp_sys = '1; exp_pwr = '1; exp_fan = '1; exp_lan = '1;
  endtask

  task automatic model_edge();
    bit tick, blink_b, g, r;
    int ph_b, ph_a;
    logic [1:0] st_on;
    tick = (mp == C - 1);
    mp   = tick ? 0 : mp + 1;
    ph_b = phase_of(on, ticks);
    blink_b = (ph_b == 3) ? bit'(((ticks - RUN_AT) / B) % 2) : 1'b0;
    for (int i = 0; i < 2; i++) st_on[i] = busy[i] && (aticks[i] < A);

    if (!ps_en) begin on = 0; ticks = 0; end
    else if (!on) begin on = 1; ticks = 0; end
    else if (tick) ticks++;
    ph_a = phase_of(on, ticks);

    exp_phase = 2'(ph_a);
    if (ph_a == 2) begin
      exp_sys = '0; exp_pwr = '0; exp_fan = '0; exp_lan = '0;
    end else if (ph_a == 3) begin
      g = (health == 2'b00) || (health == 2'b11 && blink_b);
      r = (health == 2'b10) || (health == 2'b01 && blink_b);
      exp_sys = {~g, ~r};
      exp_pwr = {~(psu_ok & ~psu_fail), ~psu_fail};
      exp_fan = {~fan_fail, fan_fail};
      exp_lan = {~l1000, ~(l100 & ~l1000), ~(st_on & (l1000 | l100))};
    end else begin
      exp_sys = '1; exp_pwr = '1; exp_fan = '1; exp_lan = '1;
    end

    for (int i = 0; i < 2; i++) begin
      if (ph_b != 3) busy[i] = 0;
      else if (busy[i]) begin
        if (tick) aticks[i]++;
        if (aticks[i] == 2 * A) busy[i] = 0;
      end else if (lan_act[i]) begin
        busy[i] = 1; aticks[i] = 0;
      end
    end
  endtask

  task automatic compare();
    check("phase", 32'(panel.LedPhase), 32'(exp_phase));
    check("sys",   32'({panel.SysLedG_ox, panel.SysLedR_ox}), 32'(exp_sys));
    check("pwr",   32'({panel.PowerNormal_ox, panel.PowerFail_ox}), 32'(exp_pwr));
    check("fan",   32'({panel.FanFail_ox, panel.FanOK_ox}), 32'(exp_fan));
    check("lan",   32'({panel.RJ45Speed1R_ox, panel.RJ45Speed2R_ox, panel.RJ45RActivity_ox}),
          32'(exp_lan));
  endtask

  // mode 0: random status, rare power drop; 1: continuous activity; 2: frequent power drops
  task automatic drive(input int mode);
    case (mode)
      1:       ps_en = 1'b1;
      2:       ps_en = ($urandom_range(0, 7) != 0);
      default: ps_en = ($urandom_range(0, 149) != 0);
    endcase
    if ($urandom_range(0, 39) == 0) health = 2'($urandom);
    if ($urandom_range(0, 19) == 0) begin
      psu_ok = 2'($urandom); psu_fail = 2'($urandom); fan_fail = 1'($urandom);
      l1000  = 2'($urandom); l100     = 2'($urandom);
    end
    if (mode == 1) lan_act = 2'b11;
    else           lan_act = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
  endtask

  task automatic cycle(input int mode);
    @(posedge Mclk);
    model_edge();
    #1;
    compare();
    drive(mode);
  endtask

  task automatic check_all_off(input string tag);
    check(tag, 32'({panel.LedPhase, panel.SysLedG_ox, panel.SysLedR_ox, panel.FanFail_ox,
                    panel.FanOK_ox, panel.PowerNormal_ox, panel.PowerFail_ox,
                    panel.RJ45Speed1R_ox, panel.RJ45Speed2R_ox, panel.RJ45RActivity_ox}),
          32'({2'b00, 14'h3fff}));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge Mclk);
    #1;
    check_all_off("reset_state");
    @(negedge Mclk);
    Reset = 1'b0;

    for (int seg = 0; seg < 10; seg++) begin
      for (int n = 0; n < 150; n++) cycle(seg % 3);
    end

    // Asynchronous reset asserted mid-RUN, between clock edges.
    ps_en = 1'b1; health = 2'b00; l1000 = 2'b01; l100 = 2'b11; lan_act = 2'b11;
    for (int n = 0; n < 80; n++) cycle(1);
    @(posedge Mclk);
    model_edge();
    #3;
    Reset = 1'b1;
    #1;
    check_all_off("async_reset");
    for (int n = 0; n < 3; n++) begin
      @(posedge Mclk);
      #1;
      check_all_off("reset_hold");
    end
    @(negedge Mclk);
    Reset = 1'b0;
    model_reset();

    for (int seg = 0; seg < 6; seg++) begin
      for (int n = 0; n < 150; n++) cycle((seg + 1) % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
